// File: rtl/systolic_data_setup_pkg.sv
// rtl/systolic_data_setup_pkg.sv - shared FSM encodings, default widths and helpers for the skew stage
//
// Purpose : common definitions imported by systolic_data_setup and its interface.
// Contents: sds_state_e   FSM states (IDLE / STREAM / DRAIN)
//           SDS_DEFAULT_DW default activation element width
//           SDS_DEFAULT_ROWS default PE row count
//           sds_cnt_w()    drain counter width, never below 1 bit
package systolic_data_setup_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DRAIN  = 2'd2
    } sds_state_e;

    localparam int SDS_DEFAULT_DW   = 8;
    localparam int SDS_DEFAULT_ROWS = 4;

    // A single-row array still needs a legal (1-bit) counter vector.
    function automatic int sds_cnt_w(input int rows);
        return (rows > 1) ? $clog2(rows) : 1;
    endfunction

endpackage

// File: rtl/systolic_data_setup_if.sv
// rtl/systolic_data_setup_if.sv - valid/ready activation-vector input bundle for the skew stage
//
// Signals : in_valid  producer has a vector
//           in_ready  skew stage can take it this cycle
//           in_data   ROWS lanes of DW bits, lane r = in_data[r*DW +: DW]
//           in_last   marks the final vector of a tile
// Modports: master = producer side, slave = systolic_data_setup side
interface systolic_data_setup_if #(
    parameter int ROWS = systolic_data_setup_pkg::SDS_DEFAULT_ROWS,
    parameter int DW   = systolic_data_setup_pkg::SDS_DEFAULT_DW
) ();

    logic                 in_valid;
    logic                 in_ready;
    logic [ROWS*DW-1:0]   in_data;
    logic                 in_last;

    modport master (
        output in_valid,
        output in_data,
        output in_last,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  in_last,
        output in_ready
    );

endinterface

// File: rtl/sds_delay_line.sv
// rtl/sds_delay_line.sv - reset-to-zero shift register of DEPTH stages, DEPTH=0 is a wire
//
// Parameters: DEPTH  number of register stages (0 = combinational passthrough)
//             W      bit width of each stage
// Ports     : clk, rst_n (async active-low), in_d (stage input), out_q (delayed output)
module sds_delay_line #(
    parameter int DEPTH = 1,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] in_d,
    output logic [W-1:0] out_q
);

    generate
        if (DEPTH == 0) begin : g_pass
            logic unused_clk_rst;
            assign unused_clk_rst = clk ^ rst_n;
            assign out_q          = in_d;
        end else begin : g_shift
            logic [W-1:0] shift_q [DEPTH];
            logic [W-1:0] shift_d [DEPTH];

            always_comb begin
                shift_d[0] = in_d;
                for (int i = 1; i < DEPTH; i++) begin
                    shift_d[i] = shift_q[i-1];
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        shift_q[i] <= '0;
                    end
                end else begin
                    for (int i = 0; i < DEPTH; i++) begin
                        shift_q[i] <= shift_d[i];
                    end
                end
            end

            assign out_q = shift_q[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/systolic_data_setup.sv
// rtl/systolic_data_setup.sv - input skew stage turning activation vectors into a diagonal wavefront
//
// Ports: clk         rising-edge clock
//        rst_n       asynchronous active-low reset
//        s           systolic_data_setup_if.slave (in_valid/in_ready/in_data/in_last)
//        out_data    lane r -> datain of PE row r, delayed r cycles behind lane 0
//        out_active  lane r -> active of PE row r
//        busy        FSM in STREAM or DRAIN
//        done        one-cycle pulse as the tile's last element leaves lane ROWS-1
//        vec_count   accepted-vector count
// Optional feature macro: SDS_STAT_EN (enables the 16-bit vec_count counter, else tied 0)
module systolic_data_setup
    import systolic_data_setup_pkg::*;
#(
    parameter int ROWS = SDS_DEFAULT_ROWS,
    parameter int DW   = SDS_DEFAULT_DW
) (
    input  logic                 clk,
    input  logic                 rst_n,
    systolic_data_setup_if.slave s,
    output logic [ROWS*DW-1:0]   out_data,
    output logic [ROWS-1:0]      out_active,
    output logic                 busy,
    output logic                 done,
    output logic [15:0]          vec_count
);

    localparam int CW = sds_cnt_w(ROWS);
    // Drain lasts ROWS-1 cycles; counter runs 0..ROWS-2.
    localparam logic [CW-1:0] LAST_CNT = CW'((ROWS > 1) ? ROWS - 2 : 0);

    sds_state_e          state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                done_q, done_d;
    logic                busy_q, busy_d;
    logic                in_act_q, in_act_d;
    logic [ROWS*DW-1:0]  in_data_q, in_data_d;
    logic                accept;

    assign s.in_ready = (state_q != ST_DRAIN);
    assign accept     = s.in_valid & s.in_ready;

    // Common input register: a bubble loads zero data with active low so
    // every lane sees the gap at its own skewed position.
    always_comb begin
        in_act_d  = accept;
        in_data_d = accept ? s.in_data : '0;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE, ST_STREAM: begin
                if (accept) begin
                    if (s.in_last) begin
                        if (ROWS == 1) begin
                            state_d = ST_IDLE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = ST_DRAIN;
                            cnt_d   = '0;
                        end
                    end else begin
                        state_d = ST_STREAM;
                    end
                end
            end
            ST_DRAIN: begin
                if (cnt_q == LAST_CNT) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            in_act_q  <= 1'b0;
            in_data_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
            in_act_q  <= in_act_d;
            in_data_q <= in_data_d;
        end
    end

    assign done = done_q;
    assign busy = busy_q;

    // Lane r adds r stages after the input register, so lane 0 has one
    // cycle of latency and lane r has r+1.
    generate
        for (genvar r = 0; r < ROWS; r++) begin : g_lane
            logic [DW:0] lane_out;

            sds_delay_line #(
                .DEPTH (r),
                .W     (DW + 1)
            ) u_delay (
                .clk   (clk),
                .rst_n (rst_n),
                .in_d  ({in_act_q, in_data_q[r*DW +: DW]}),
                .out_q (lane_out)
            );

            assign out_active[r]         = lane_out[DW];
            assign out_data[r*DW +: DW]  = lane_out[DW-1:0];
        end
    endgenerate

`ifdef SDS_STAT_EN
    logic [15:0] vec_count_q, vec_count_d;

    always_comb begin
        vec_count_d = accept ? vec_count_q + 16'd1 : vec_count_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec_count_q <= '0;
        end else begin
            vec_count_q <= vec_count_d;
        end
    end

    assign vec_count = vec_count_q;
`else
    assign vec_count = '0;
`endif

endmodule

// File: tb/tb_systolic_data_setup.sv
// tb/tb_systolic_data_setup.sv - self-checking bench for systolic_data_setup (ROWS=4, DW=8)
module tb_systolic_data_setup;

    localparam int ROWS = 4;
    localparam int DW   = 8;

    logic                clk;
    logic                rst_n;
    logic [ROWS*DW-1:0]  out_data;
    logic [ROWS-1:0]     out_active;
    logic                busy;
    logic                done;
    logic [15:0]         vec_count;

    systolic_data_setup_if #(.ROWS(ROWS), .DW(DW)) ifc ();

    systolic_data_setup #(.ROWS(ROWS), .DW(DW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .s          (ifc),
        .out_data   (out_data),
        .out_active (out_active),
        .busy       (busy),
        .done       (done),
        .vec_count  (vec_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: history of what was accepted (or a bubble) at each edge since reset.
    logic [ROWS*DW-1:0] hist_data[$];
    bit                 hist_act[$];
    int                 ec = 0;
    bit                 have_last = 0;
    int                 last_k = 0;
    bit                 tile_open = 0;
    int                 acc_cnt = 0;
    int                 done_seen = 0;
    bit                 ff_seen = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (edge %0d)", name, act, exp, ec);
        end
    endtask

    task automatic compare_outputs();
        logic [ROWS*DW-1:0] exp_d;
        logic [ROWS-1:0]    exp_a;
        logic [15:0]        exp_cnt;
        exp_d = '0;
        exp_a = '0;
        for (int r = 0; r < ROWS; r++) begin
            int idx;
            idx = hist_act.size() - 1 - r;
            if (idx >= 0 && hist_act[idx]) begin
                exp_a[r]           = 1'b1;
                exp_d[r*DW +: DW]  = hist_data[idx][r*DW +: DW];
            end
        end
`ifdef SDS_STAT_EN
        exp_cnt = 16'(acc_cnt);
`else
        exp_cnt = 16'd0;
`endif
        chk("out_data",   64'(out_data),   64'(exp_d));
        chk("out_active", 64'(out_active), 64'(exp_a));
        chk("done",  64'(done), 64'(have_last && ec == last_k + ROWS - 1));
        chk("busy",  64'(busy), 64'(tile_open || (have_last && ec < last_k + ROWS - 1)));
        chk("vec_count", 64'(vec_count), 64'(exp_cnt));
        if (done) done_seen++;
        for (int r = 0; r < ROWS; r++) begin
            if (out_data[r*DW +: DW] == 8'hFF) ff_seen = 1'b1;
        end
    endtask

    task automatic step(input bit v, input bit l, input logic [ROWS*DW-1:0] d);
        bit exp_ready;
        bit acc;
        @(negedge clk);
        ifc.in_valid = v;
        ifc.in_last  = l;
        ifc.in_data  = d;
        #1;
        exp_ready = !(have_last && (ec + 1) > last_k && (ec + 1) <= last_k + ROWS - 1);
        chk("in_ready", 64'(ifc.in_ready), 64'(exp_ready));
        acc = v && exp_ready;
        @(posedge clk);
        ec++;
        hist_act.push_back(acc);
        hist_data.push_back(acc ? d : '0);
        if (acc) begin
            acc_cnt++;
            if (l) begin
                have_last = 1'b1;
                last_k    = ec;
                tile_open = 1'b0;
            end else begin
                tile_open = 1'b1;
            end
        end
        #1;
        compare_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n        = 1'b0;
        ifc.in_valid = 1'b0;
        ifc.in_last  = 1'b0;
        ifc.in_data  = '0;
        hist_data.delete();
        hist_act.delete();
        have_last = 1'b0;
        tile_open = 1'b0;
        acc_cnt   = 0;
        #1;
        chk("rst_out_data",   64'(out_data),     64'd0);
        chk("rst_out_active", 64'(out_active),   64'd0);
        chk("rst_done",       64'(done),         64'd0);
        chk("rst_busy",       64'(busy),         64'd0);
        chk("rst_in_ready",   64'(ifc.in_ready), 64'd1);
        chk("rst_vec_count",  64'(vec_count),    64'd0);
        @(posedge clk);
        ec++;
        #1;
        compare_outputs();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int d0;
        rst_n        = 1'b1;
        ifc.in_valid = 1'b0;
        ifc.in_last  = 1'b0;
        ifc.in_data  = '0;
        do_reset();
        idle(2);

        // Three back-to-back vectors A,B,C (C last): lane 2 carries A2,B2,C2.
        d0 = done_seen;
        step(1'b1, 1'b0, 32'hA3A2A1A0);
        step(1'b1, 1'b0, 32'hB3B2B1B0);
        step(1'b1, 1'b1, 32'hC3C2C1C0);
        chk("abc_lane2_A", 64'({out_active[2], out_data[23:16]}), 64'h1A2);
        step(1'b0, 1'b0, '0);
        chk("abc_lane2_B", 64'({out_active[2], out_data[23:16]}), 64'h1B2);
        step(1'b0, 1'b0, '0);
        chk("abc_lane2_C", 64'({out_active[2], out_data[23:16]}), 64'h1C2);
        step(1'b0, 1'b0, '0);
        chk("abc_lane2_off", 64'(out_active[2]), 64'd0);
        chk("abc_done_k5",   64'(done), 64'd1);
        idle(2);
        chk("abc_done_once", 64'(done_seen - d0), 64'd1);

        // Bubble between A and B.
        step(1'b1, 1'b0, 32'h14131211);
        step(1'b0, 1'b0, '0);
        step(1'b1, 1'b1, 32'h24232221);
        chk("bub_lane1", 64'({out_active[1], out_data[15:8]}), 64'h000);
        chk("bub_lane2", 64'({out_active[2], out_data[23:16]}), 64'h113);
        idle(5);
`ifdef SDS_STAT_EN
        chk("stat_five", 64'(vec_count), 64'd5);
`else
        chk("stat_off", 64'(vec_count), 64'd0);
`endif

        // Single vector {04,03,02,01} with in_last.
        step(1'b1, 1'b1, 32'h04030201);
        chk("one_lane0", 64'({out_active[0], out_data[7:0]}), 64'h101);
        chk("one_ready_lo", 64'(ifc.in_ready), 64'd0);
        step(1'b0, 1'b0, '0);
        chk("one_lane1", 64'({out_active[1], out_data[15:8]}), 64'h102);
        step(1'b0, 1'b0, '0);
        chk("one_lane2", 64'({out_active[2], out_data[23:16]}), 64'h103);
        step(1'b0, 1'b0, '0);
        chk("one_lane3", 64'({out_active[3], out_data[31:24]}), 64'h104);
        chk("one_done",  64'(done), 64'd1);
        chk("one_ready_hi", 64'(ifc.in_ready), 64'd1);
        idle(2);

        // in_valid with FF data during DRAIN must not be taken.
        ff_seen = 1'b0;
        step(1'b1, 1'b1, 32'h55555555);
        step(1'b1, 1'b0, 32'hFFFFFFFF);
        step(1'b1, 1'b1, 32'hFFFFFFFF);
        step(1'b1, 1'b0, 32'hFFFFFFFF);
        idle(6);
        chk("drain_no_ff", 64'(ff_seen), 64'd0);

        // Reset mid-stream: lanes flush, no done pulse afterwards.
        step(1'b1, 1'b0, 32'h0D0C0B0A);
        step(1'b1, 1'b1, 32'h1D1C1B1A);
        d0 = done_seen;
        do_reset();
        idle(6);
        chk("rst_no_done", 64'(done_seen - d0), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
